// File: rtl/reg32_write_arb.sv
// rtl/reg32_write_arb.sv - three-requester round-robin write arbiter for one 32-bit register
//
// Purpose:
//   Arbitrates half-word and full-word write requests from three requesters
//   and is the only writer of a single 32-bit register. Half writes merge
//   the new 16-bit beat with the current register value. Full writes arrive
//   as two beats, low half first. If the high beat does not arrive within
//   TIMEOUT cycles, the full write is aborted.
//
// Parameters:
//   TIMEOUT     - max cycles spent in HI_WAIT waiting for the high beat (1..255)
//
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   req_valid   - [2:0]  per-requester request valid
//   req_mode    - [5:0]  per-requester mode, 2 bits each:
//                        00 low half, 01 high half, 10 full (two beats), 11 reserved
//   req_data    - [47:0] per-requester 16-bit beat
//   req_ready   - [2:0]  one-hot or zero; a beat moves when valid & ready
//   reg_q       - [31:0] current value of the controlled register
//   reg_load    - load enable for the controlled register
//   reg_d       - [31:0] data for the controlled register (zero unless reg_load)
//   grant_id    - [1:0]  requester that owns the current transaction
//   busy        - high whenever the FSM is not in IDLE
//   err_timeout - one-cycle pulse when a full write is abandoned

module reg32_write_arb #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_valid,
  input  logic [5:0]  req_mode,
  input  logic [47:0] req_data,
  output logic [2:0]  req_ready,
  input  logic [31:0] reg_q,
  output logic        reg_load,
  output logic [31:0] reg_d,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HI_WAIT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LO   = 2'b00;
  localparam logic [1:0] MODE_HI   = 2'b01;
  localparam logic [1:0] MODE_FULL = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic [1:0]  last_grant;
  logic [7:0]  wait_cnt;
  logic [15:0] low_q;
  logic [15:0] beat_q;
  logic [1:0]  mode_q;

  // Per-requester views; entry 3 is padding so a 2-bit index never goes out of range.
  logic [1:0]  mode_a  [4];
  logic [15:0] data_a  [4];
  logic [3:0]  eligible;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      mode_a[i]   = req_mode[2*i +: 2];
      data_a[i]   = req_data[16*i +: 16];
      eligible[i] = req_valid[i] && (req_mode[2*i +: 2] != MODE_RSVD);
    end
    mode_a[3]   = 2'b00;
    data_a[3]   = 16'h0000;
    eligible[3] = 1'b0;
  end

  // Round-robin search starting one past the last granted requester.
  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] rr_start;
  logic [2:0] rr_cand;

  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    rr_cand   = 3'd0;
    rr_start  = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
    for (int k = 0; k < 3; k++) begin
      rr_cand = {1'b0, rr_start} + 3'(k);
      if (rr_cand >= 3'd3) begin
        rr_cand = rr_cand - 3'd3;
      end
      if (!win_found && eligible[rr_cand[1:0]]) begin
        win_found = 1'b1;
        win_id    = rr_cand[1:0];
      end
    end
  end

  logic [1:0]  win_mode;
  logic [15:0] win_data;
  logic        hi_beat;

  assign win_mode = mode_a[win_id];
  assign win_data = data_a[win_id];
  // In HI_WAIT the owner's beat is always the high half, whatever its mode bits say.
  assign hi_beat  = req_valid[grant_id];

  // Ready is combinational so a requester sees it in the same cycle it asserts valid.
  // Held low during reset so no beat can appear to transfer.
  always_comb begin
    req_ready = 3'b000;
    if (rst_n) begin
      case (state)
        IDLE:    if (win_found) req_ready = 3'b001 << win_id;
        HI_WAIT: req_ready = 3'b001 << grant_id;
        default: req_ready = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 2'd2;
      grant_id    <= 2'd0;
      busy        <= 1'b0;
      reg_load    <= 1'b0;
      err_timeout <= 1'b0;
      wait_cnt    <= 8'd0;
      low_q       <= 16'h0000;
      beat_q      <= 16'h0000;
      mode_q      <= MODE_LO;
    end else begin
      reg_load    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_id <= win_id;
            busy     <= 1'b1;
            if (win_mode == MODE_FULL) begin
              low_q    <= win_data;
              mode_q   <= MODE_FULL;
              wait_cnt <= 8'd0;
              state    <= HI_WAIT;
            end else begin
              beat_q     <= win_data;
              mode_q     <= win_mode;
              last_grant <= win_id;
              reg_load   <= 1'b1;
              state      <= LOAD;
            end
          end
        end

        HI_WAIT: begin
          if (hi_beat) begin
            beat_q     <= data_a[grant_id];
            last_grant <= grant_id;
            reg_load   <= 1'b1;
            state      <= LOAD;
          end else if (wait_cnt + 8'd1 == TIMEOUT_CNT) begin
            // Abandon: drop the staged low half and let others in.
            low_q       <= 16'h0000;
            wait_cnt    <= 8'd0;
            err_timeout <= 1'b1;
            last_grant  <= grant_id;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        LOAD: begin
          // The IDLE cycle that follows lets reg_q settle before the next merge.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    reg_d = 32'h0000_0000;
    if (reg_load) begin
      case (mode_q)
        MODE_LO: reg_d = {reg_q[31:16], beat_q};
        MODE_HI: reg_d = {beat_q, reg_q[15:0]};
        default: reg_d = {beat_q, low_q};
      endcase
    end
  end

endmodule

// File: tb/tb_reg32_write_arb.sv
// tb/tb_reg32_write_arb.sv - directed self-checking bench for reg32_write_arb

module tb_reg32_write_arb;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [5:0]  req_mode;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic [31:0] reg_q;
  logic        reg_load;
  logic [31:0] reg_d;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_timeout;

  logic        preset_en;
  logic [31:0] preset_val;

  int n_total;
  int n_pass;

  reg32_write_arb #(.TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_mode    (req_mode),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .reg_q       (reg_q),
    .reg_load    (reg_load),
    .reg_d       (reg_d),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The controlled register, written only by the DUT (or preset by the bench).
  always @(posedge clk) begin
    if (preset_en) reg_q <= preset_val;
    else if (reg_load) reg_q <= reg_d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [31:0] v);
    preset_val = v;
    preset_en  = 1'b1;
    tick();
    preset_en  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_req(input int id, input logic [1:0] mode, input logic [15:0] data);
    req_mode[2*id +: 2]  = mode;
    req_data[16*id +: 16] = data;
  endtask

  logic [2:0]  exp_id [6];
  logic [31:0] exp_d  [6];

  initial begin
    n_total    = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    preset_en  = 1'b0;
    preset_val = 32'h0;
    reg_q      = 32'h0;
    req_valid  = 3'b111;
    req_mode   = 6'b000000;
    req_data   = 48'h0;

    // Reset state, with requests pending to show ready is held off.
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_load", 32'(reg_load), 32'h0);
    check("rst_err", 32'(err_timeout), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_reg_d", reg_d, 32'h0);
    req_valid = 3'b000;
    rst_n = 1'b1;
    tick();

    // Low-half write merges with reg_q.
    preset(32'h1234_5678);
    req_valid = 3'b001;
    set_req(0, 2'b00, 16'hAAAA);
    #1 check("lo_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b000;
    #1;
    check("lo_load", 32'(reg_load), 32'h1);
    check("lo_reg_d", reg_d, 32'h1234_AAAA);
    check("lo_busy", 32'(busy), 32'h1);
    check("lo_ready_load", 32'(req_ready), 32'h0);
    tick();
    check("lo_load_done", 32'(reg_load), 32'h0);
    check("lo_idle", 32'(busy), 32'h0);

    // Full write from requester 1, high beat two cycles later with reserved mode bits.
    req_valid = 3'b010;
    set_req(1, 2'b10, 16'h5555);
    #1 check("full_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b001;
    set_req(0, 2'b00, 16'h0BAD);
    #1;
    check("full_wait_ready", 32'(req_ready), 32'h2);
    check("full_wait_busy", 32'(busy), 32'h1);
    check("full_wait_grant", 32'(grant_id), 32'h1);
    check("full_wait_noload", 32'(reg_load), 32'h0);
    tick();
    req_valid = 3'b010;
    set_req(1, 2'b11, 16'h6666);
    #1 check("full_hi_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b000;
    #1;
    check("full_load", 32'(reg_load), 32'h1);
    check("full_reg_d", reg_d, 32'h6666_5555);
    tick();

    // Round robin from a fresh reset: 0,1,2,0,1,2, one grant every two cycles.
    do_reset();
    preset(32'hDEAD_BEEF);
    set_req(0, 2'b00, 16'h1111);
    set_req(1, 2'b01, 16'h2222);
    set_req(2, 2'b00, 16'h3333);
    exp_id = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
    exp_d  = '{32'hDEAD_1111, 32'h2222_1111, 32'h2222_3333,
               32'h2222_1111, 32'h2222_1111, 32'h2222_3333};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'h1 << exp_id[k]);
      tick();
      check($sformatf("rr_grant%0d", k), 32'(grant_id), 32'(exp_id[k]));
      check($sformatf("rr_load%0d", k), 32'(reg_load), 32'h1);
      check($sformatf("rr_reg_d%0d", k), reg_d, exp_d[k]);
      check($sformatf("rr_ready_load%0d", k), 32'(req_ready), 32'h0);
      tick();
    end
    req_valid = 3'b000;
    tick();

    // Timeout on requester 2; others wait, then requester 0 is next.
    req_valid = 3'b100;
    set_req(2, 2'b10, 16'h7777);
    set_req(0, 2'b00, 16'hCCCC);
    set_req(1, 2'b00, 16'hDDDD);
    #1 check("to_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 3'b011;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (err_timeout !== 1'b0 || reg_load !== 1'b0 || req_ready !== 3'b100)
        check($sformatf("to_wait%0d", c), {err_timeout, reg_load, req_ready}, {2'b00, 3'b100});
    end
    check("to_wait_busy", 32'(busy), 32'h1);
    tick();
    check("to_err", 32'(err_timeout), 32'h1);
    check("to_noload", 32'(reg_load), 32'h0);
    check("to_idle", 32'(busy), 32'h0);
    check("to_next_ready", 32'(req_ready), 32'h1);
    tick();
    check("to_err_pulse", 32'(err_timeout), 32'h0);
    check("to_next_grant", 32'(grant_id), 32'h0);
    check("to_next_load", 32'(reg_load), 32'h1);
    req_valid = 3'b000;
    tick();

    // Reset during HI_WAIT, then a fresh merge.
    preset(32'hCAFE_F00D);
    req_valid = 3'b010;
    set_req(1, 2'b10, 16'h4444);
    tick();
    req_valid = 3'b000;
    #1 check("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_grant", 32'(grant_id), 32'h0);
    tick();
    check("mid_rst_load", 32'(reg_load), 32'h0);
    rst_n = 1'b1;
    tick();
    check("mid_after_load", 32'(reg_load), 32'h0);
    req_valid = 3'b001;
    set_req(0, 2'b00, 16'hBBBB);
    #1 check("mid_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b000;
    #1 check("mid_reg_d", reg_d, 32'hCAFE_BBBB);
    tick();

    // Reserved mode on requester 0 is never served, even when it has priority.
    do_reset();
    preset(32'h1111_2222);
    set_req(0, 2'b11, 16'hEEEE);
    set_req(1, 2'b01, 16'h9999);
    req_valid = 3'b011;
    for (int k = 0; k < 2; k++) begin
      #1 check($sformatf("rsvd_ready%0d", k), 32'(req_ready), 32'h2);
      tick();
      check($sformatf("rsvd_grant%0d", k), 32'(grant_id), 32'h1);
      check($sformatf("rsvd_reg_d%0d", k), reg_d, 32'h9999_2222);
      tick();
    end
    req_valid = 3'b000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
